ac2_rr_mux: RTL
===============

// Module: ac2_rr_mux
// PURPOSE
//  N-channel registered arbiter-mux between the shift-register outputs and AC2_adder.
//  Generalises the fixed 4:1 select: N channels, each with a valid/ready handshake.
//  Selection is round-robin, with an optional forced-channel mode compatible with sel_w_en.
//  Output is a single register stage with valid/ready toward the adder.
// PARAMETERS
//  M   16  shift register dimension; sets data width
//  Pa  8   activation precision; sets data width
//  N   4   number of input channels (>=2)
//  W   = $clog2(M)+Pa+1 (local): data width per channel, 13 at defaults
//  CW  = $clog2(N) (local): channel index width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  in_data      in   N*W   packed channel data, ch i at [i*W +: W]
//  in_valid     in   N     channel i holds a result
//  in_ready     out  N     one-hot; ch i's word is taken this cycle
//  force_en     in   1     1 = only channel force_sel is eligible
//  force_sel    in   CW    forced channel index (legacy sel_w_en)
//  out_data     out  W     registered word to AC2_adder
//  out_ch       out  CW    source channel of out_data
//  out_valid    out  1     out_data valid
//  out_ready    in   1     adder accepts out_data
//  out_count    out  16    accepted output beats (AC2_MUX_STATS_EN only)
// BEHAVIOUR
//  - Async reset, all outputs zero:
//    - out_valid=0, out_data=0, out_ch=0, in_ready=0.
//    - rr pointer=0; out_count=0.
//  - load = !out_valid | out_ready. in_ready is combinational and is 0 when load=0.
//  - Eligible set E = in_valid, masked to bit force_sel when force_en=1.
//    - force_sel>=N: E=0, nothing is granted.
//  - Grant (when load & |E): first set bit of E scanning ptr, ptr+1, ... wrapping mod N.
//    - in_ready[g]=1.
//    - Next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1, ptr<=(g+1) mod N.
//  - load & E==0: out_valid<=0. out_data and out_ch hold their last values.
//  - Stall (out_valid & !out_ready):
//    - out_data, out_ch, ptr hold.
//    - in_ready=0.
//    - Inputs are not consumed.
//  - Latency:
//    - 1 cycle from grant to out_valid.
//    - A full-rate stream is possible: drain and reload happen in the same cycle.
//  - Fairness: with every channel valid, grants cycle 0,1,..,N-1,0.
//    - No channel waits more than N grants.
//  - Forced mode does not advance the rr pointer past non-forced channels.
//    - ptr<=force_sel+1 on a grant, as above.
//  - Data passes unmodified; no width change or arithmetic.
//  - Mid-operation reset drops the held word and any pending grant. Channels re-present afterwards.
// CONFIGURATION
//  AC2_MUX_STATS_EN defined:
//    - out_count port exists.
//    - Increments on each out_valid & out_ready.
//    - Saturates at 16'hFFFF; cleared by rst_n.
//  Not defined: port and counter are absent. All other behaviour is identical.
// TESTING
//  - Reset: rst_n=0 mid-stream.
//    -> out_valid=0, out_data=0, in_ready=0 immediately (asynchronous).
//  - Round robin: N=4, in_valid=4'b1111, out_ready=1, ch i data=i+5.
//    -> out_ch 0,1,2,3,0.
//    -> out_data 5,6,7,8,5, one per cycle from cycle 1.
//  - Backpressure: out_ready=0 for 3 cycles with out_data=6.
//    -> out_data=6 stable, in_ready=0.
//    -> On release the next grant is ch2.
//  - Sparse/wrap:
//    - ptr=3, in_valid=4'b0010 -> ch1 granted, ptr becomes 2.
//    - in_valid=0 -> out_valid drops after the accept.
//  - Forced: force_en=1, force_sel=2, in_valid=4'b1111.
//    -> only ch2 is granted each beat.
//    -> force_sel=5 (N=8 build, ch5 invalid) -> no grant.
//  - Stats (AC2_MUX_STATS_EN): 70000 accepted beats -> out_count=16'hFFFF, holds.

Source files
------------

// File: rtl/ac2_rr_mux_if.sv
// Handshake bundle between shift-register channels, the rr mux and AC2_adder.
// out_count exists only when AC2_MUX_STATS_EN is defined.
interface ac2_rr_mux_if #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int N  = 4
);
  localparam int W  = $clog2(M) + Pa + 1;
  localparam int CW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           force_en;
  logic [CW-1:0]  force_sel;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
`ifdef AC2_MUX_STATS_EN
  logic [15:0]    out_count;
`endif

  modport slave (
    input  in_data, in_valid, force_en,
    input  force_sel, out_ready,
    output in_ready, out_data, out_ch,
    output out_valid
`ifdef AC2_MUX_STATS_EN
    , output out_count
`endif
  );

  modport master (
    output in_data, in_valid, force_en,
    output force_sel, out_ready,
    input  in_ready, out_data, out_ch,
    input  out_valid
`ifdef AC2_MUX_STATS_EN
    , input out_count
`endif
  );
endinterface

// File: rtl/ac2_rr_mux.sv
// N-channel round-robin registered arbiter-mux feeding AC2_adder.
// Optional beat counter guarded by AC2_MUX_STATS_EN.
module ac2_rr_mux #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int N  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ac2_rr_mux_if.slave bus
);
  localparam int W  = $clog2(M) + Pa + 1;
  localparam int CW = $clog2(N);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_ch;
  logic          r_valid;
  logic [CW-1:0] r_ptr;

  logic [N-1:0]  w_elig;
  logic          w_any;
  logic [CW-1:0] w_gidx;
  logic [CW-1:0] w_nxt;
  logic [CW:0]   w_j;
  logic          w_load;
  logic          w_take;
  logic [N-1:0]  w_rdy;

  assign w_load = !r_valid | bus.out_ready;
  assign w_take = rst_n & w_load & w_any;

  // Eligible set: all valid channels, or only the forced one
  always_comb begin
    w_elig = '0;
    if (!bus.force_en) begin
      w_elig = bus.in_valid;
    end else if ({1'b0, bus.force_sel} < (CW+1)'(N)) begin
      w_elig[bus.force_sel] = bus.in_valid[bus.force_sel];
    end
  end

  // First eligible channel scanning from r_ptr, wrapping mod N
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_j    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j = {1'b0, r_ptr} + (CW+1)'(i);
      if (w_j >= (CW+1)'(N)) w_j = w_j - (CW+1)'(N);
      if (w_elig[w_j[CW-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_j[CW-1:0];
      end
    end
  end

  assign w_nxt = (w_gidx == CW'(N - 1)) ? '0 : w_gidx + 1'b1;

  // One-hot take strobe toward the granted channel
  always_comb begin
    w_rdy = '0;
    if (w_take) w_rdy[w_gidx] = 1'b1;
  end

  // Output register: reload on grant, drop valid when idle, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_data  <= bus.in_data[w_gidx*W +: W];
        r_ch    <= w_gidx;
        r_valid <= 1'b1;
        r_ptr   <= w_nxt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_rdy;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.out_valid = r_valid;

`ifdef AC2_MUX_STATS_EN
  logic [15:0] r_count;

  // Saturating count of beats accepted by the adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_valid && bus.out_ready &&
                 r_count != 16'hFFFF) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign bus.out_count = r_count;
`endif
endmodule
